// File: rtl/rap16_errmon.sv
// rap16_errmon: windowed error-distance statistics for the RAP16 approximate adder.
// Define RAP_ERRMON_MSE_EN to add the squared-error sum port.
module rap16_errmon #(
  parameter int LOG_WIN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_a,
  input  logic [15:0]         in_b,
  input  logic [16:0]         in_sum,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LOG_WIN:0]    out_err_cnt,
  output logic [16+LOG_WIN:0] out_ed_sum,
  output logic [16:0]         out_max_ed
`ifdef RAP_ERRMON_MSE_EN
  ,
  output logic [33+LOG_WIN:0] out_se_sum
`endif
);
  logic [LOG_WIN-1:0]  r_cnt;
  logic                r_s1_valid, r_s1_nz, r_s1_last, r_out_valid;
  logic [16:0]         r_s1_ed, r_max_acc, r_max_out;
  logic [LOG_WIN:0]    r_err_acc, r_err_out;
  logic [16+LOG_WIN:0] r_ed_acc, r_ed_out;
  logic [16:0]         w_exact, w_ed, w_max_nx;
  logic signed [17:0]  w_diff;
  logic                w_stall, w_fire, w_emit;
  logic [LOG_WIN:0]    w_err_nx;
  logic [16+LOG_WIN:0] w_ed_nx;

  assign w_exact  = {1'b0, in_a} + {1'b0, in_b};
  assign w_diff   = $signed({1'b0, w_exact}) - $signed({1'b0, in_sum});
  assign w_ed     = w_diff[17] ? 17'(-w_diff) : w_diff[16:0];
  // Only the window-closing sample can be blocked, and only by an unread result
  assign w_stall  = r_s1_valid & r_s1_last & r_out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_fire   = r_s1_valid & ~w_stall & ~clr;
  assign w_emit   = w_fire & r_s1_last;
  assign w_err_nx = r_err_acc + (LOG_WIN+1)'(r_s1_nz);
  assign w_ed_nx  = r_ed_acc + (17+LOG_WIN)'(r_s1_ed);
  assign w_max_nx = r_s1_ed > r_max_acc ? r_s1_ed : r_max_acc;

  assign out_valid   = r_out_valid;
  assign out_err_cnt = r_err_out;
  assign out_ed_sum  = r_ed_out;
  assign out_max_ed  = r_max_out;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_ed    <= '0;
      r_s1_nz    <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (clr) begin
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_ed   <= w_ed;
        r_s1_nz   <= |w_ed;
        r_s1_last <= &r_cnt;
        r_cnt     <= r_cnt + LOG_WIN'(1);
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_err_acc   <= '0;
      r_ed_acc    <= '0;
      r_max_acc   <= '0;
      r_err_out   <= '0;
      r_ed_out    <= '0;
      r_max_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (clr || w_emit) begin
        r_err_acc <= '0;
        r_ed_acc  <= '0;
        r_max_acc <= '0;
      end else if (w_fire) begin
        r_err_acc <= w_err_nx;
        r_ed_acc  <= w_ed_nx;
        r_max_acc <= w_max_nx;
      end
      if (w_emit) begin
        r_err_out   <= w_err_nx;
        r_ed_out    <= w_ed_nx;
        r_max_out   <= w_max_nx;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end

`ifdef RAP_ERRMON_MSE_EN
  logic [33:0]         w_sq;
  logic [33+LOG_WIN:0] r_se_acc, r_se_out, w_se_nx;

  assign w_sq       = 34'(r_s1_ed) * 34'(r_s1_ed);
  assign w_se_nx    = r_se_acc + (34+LOG_WIN)'(w_sq);
  assign out_se_sum = r_se_out;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_se_acc <= '0;
      r_se_out <= '0;
    end else begin
      if (clr || w_emit)
        r_se_acc <= '0;
      else if (w_fire)
        r_se_acc <= w_se_nx;
      if (w_emit)
        r_se_out <= w_se_nx;
    end
`endif
endmodule
